// File: rtl/simple_fpga_cvs_pkg.sv
// Shared types and default timing constants for the MMCM reset sequencer.
// Defaults assume the free-running 300 MHz differential oscillator.
package simple_fpga_cvs_pkg;

    typedef enum logic [1:0] {
        RESET_MMCM = 2'd0,
        WAIT_LOCK  = 2'd1,
        HOLD       = 2'd2,
        RUN        = 2'd3
    } mmcm_seq_state_t;

    localparam int unsigned DefRstCycles   = 16;
    localparam int unsigned DefLockTimeout = 65536;  // ~218 us at 300 MHz
    localparam int unsigned DefHoldCycles  = 1024;
    localparam int unsigned DefSyncStages  = 2;
    localparam int unsigned DefRetryW      = 8;

    function automatic int unsigned max3(input int unsigned a, input int unsigned b,
                                         input int unsigned c);
        int unsigned m;
        m = (a > b) ? a : b;
        return (m > c) ? m : c;
    endfunction

endpackage

// File: rtl/bit_synchronizer.sv
// Multi-flop synchroniser for a single asynchronous level.
// Ports:
//   clk_i   destination clock
//   rst_ni  synchronous active-low reset, clears every stage to 0
//   d_i     asynchronous input
//   q_o     synchronised output, STAGES cycles of latency
module bit_synchronizer #(
    parameter int unsigned STAGES = 2
) (
    input  logic clk_i,
    input  logic rst_ni,
    input  logic d_i,
    output logic q_o
);

    // Pure flop chain: no logic between stages so metastability has a full period to settle.
    logic [STAGES-1:0] sync_q;

    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            sync_q <= '0;
        end else begin
            sync_q <= {sync_q[STAGES-2:0], d_i};
        end
    end

    assign q_o = sync_q[STAGES-1];

endmodule

// File: rtl/mmcm_reset_sequencer.sv
// MMCM reset sequencer. Clocked by the free-running oscillator (IBUFDS output) so it keeps
// running while the MMCM is held in reset. Drives MMCM RST, watches LOCKED, and releases a
// downstream synchronous reset only after lock has been stable; retries on timeout or loss.
// Ports:
//   clk_i          free-running oscillator clock
//   rst_ni         synchronous active-low block reset (outranks everything)
//   soft_rst_i     synchronous pulse restarting the MMCM sequence
//   mmcm_locked_i  MMCM LOCKED, asynchronous to clk_i
//   mmcm_rst_o     MMCM RST, active-high
//   sys_rst_no     downstream synchronous active-low reset
//   lock_lost_o    sticky flag: lock dropped while running
//   timeout_o      one-cycle pulse per lock timeout
//   retry_count_o  saturating count of lock timeouts
//   state_o        current sequencer state (debug)
module mmcm_reset_sequencer
    import simple_fpga_cvs_pkg::*;
#(
    parameter int unsigned RST_CYCLES   = DefRstCycles,
    parameter int unsigned LOCK_TIMEOUT = DefLockTimeout,
    parameter int unsigned HOLD_CYCLES  = DefHoldCycles,
    parameter int unsigned SYNC_STAGES  = DefSyncStages,
    parameter int unsigned RETRY_W      = DefRetryW
) (
    input  logic               clk_i,
    input  logic               rst_ni,
    input  logic               soft_rst_i,
    input  logic               mmcm_locked_i,
    output logic               mmcm_rst_o,
    output logic               sys_rst_no,
    output logic               lock_lost_o,
    output logic               timeout_o,
    output logic [RETRY_W-1:0] retry_count_o,
    output logic [1:0]         state_o
);

    localparam int unsigned CntMax = max3(RST_CYCLES, LOCK_TIMEOUT, HOLD_CYCLES);
    localparam int unsigned CntW   = $clog2(CntMax + 1);

    logic locked_sync;

    bit_synchronizer #(
        .STAGES (SYNC_STAGES)
    ) u_locked_sync (
        .clk_i  (clk_i),
        .rst_ni (rst_ni),
        .d_i    (mmcm_locked_i),
        .q_o    (locked_sync)
    );

    mmcm_seq_state_t    state_q, state_d;
    logic [CntW-1:0]    cnt_q, cnt_d;
    logic [RETRY_W-1:0] retry_q, retry_d;
    logic               lock_lost_q, lock_lost_d;
    logic               timeout_q, timeout_d;
    logic               mmcm_rst_q, sys_rst_nq;

    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        retry_d     = retry_q;
        lock_lost_d = lock_lost_q;
        timeout_d   = 1'b0;

        case (state_q)
            RESET_MMCM: begin
                cnt_d = cnt_q + 1'b1;
                if (cnt_q == CntW'(RST_CYCLES - 1)) begin
                    state_d = WAIT_LOCK;
                end
            end
            WAIT_LOCK: begin
                cnt_d = cnt_q + 1'b1;
                // Lock wins over a timeout landing on the same cycle.
                if (locked_sync) begin
                    state_d = HOLD;
                end else if (cnt_q == CntW'(LOCK_TIMEOUT - 1)) begin
                    state_d   = RESET_MMCM;
                    timeout_d = 1'b1;
                    if (retry_q != '1) begin
                        retry_d = retry_q + 1'b1;
                    end
                end
            end
            HOLD: begin
                cnt_d = cnt_q + 1'b1;
                if (!locked_sync) begin
                    state_d = WAIT_LOCK;
                end else if (cnt_q == CntW'(HOLD_CYCLES - 1)) begin
                    state_d = RUN;
                end
            end
            RUN: begin
                if (!locked_sync) begin
                    state_d     = RESET_MMCM;
                    lock_lost_d = 1'b1;
                end
            end
            default: state_d = RESET_MMCM;
        endcase

        // Soft restart overrides timeout/lock transitions but still records a lock loss.
        if (soft_rst_i) begin
            state_d   = RESET_MMCM;
            timeout_d = 1'b0;
            retry_d   = retry_q;
        end

        if (soft_rst_i || (state_d != state_q)) begin
            cnt_d = '0;
        end
    end

    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            state_q     <= RESET_MMCM;
            cnt_q       <= '0;
            retry_q     <= '0;
            lock_lost_q <= 1'b0;
            timeout_q   <= 1'b0;
            mmcm_rst_q  <= 1'b1;
            sys_rst_nq  <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            retry_q     <= retry_d;
            lock_lost_q <= lock_lost_d;
            timeout_q   <= timeout_d;
            // Decoded from the next state so both resets move on the same edge as the state.
            mmcm_rst_q  <= (state_d == RESET_MMCM);
            sys_rst_nq  <= (state_d == RUN);
        end
    end

    assign mmcm_rst_o    = mmcm_rst_q;
    assign sys_rst_no    = sys_rst_nq;
    assign lock_lost_o   = lock_lost_q;
    assign timeout_o     = timeout_q;
    assign retry_count_o = retry_q;
    assign state_o       = state_q;

endmodule

// File: tb/tb_mmcm_reset_sequencer.sv
// Self-checking bench for mmcm_reset_sequencer: cycle-level behavioural model plus directed
// scenarios with hand-computed expectations.
module tb_mmcm_reset_sequencer;

    localparam int unsigned RSTC  = 4;
    localparam int unsigned LTO   = 32;
    localparam int unsigned HOLDC = 8;
    localparam int unsigned SYNC  = 2;
    localparam int unsigned RW    = 2;
    localparam int RetryMax = (1 << RW) - 1;

    localparam int MReset = 0;
    localparam int MWait  = 1;
    localparam int MHold  = 2;
    localparam int MRun   = 3;

    logic          clk = 1'b0;
    logic          rst_n;
    logic          soft_rst;
    logic          mmcm_locked;
    logic          mmcm_rst;
    logic          sys_rst_n;
    logic          lock_lost;
    logic          timeout;
    logic [RW-1:0] retry_count;
    logic [1:0]    state;

    int n_tests = 0;
    int n_fail  = 0;

    always #5 clk = ~clk;

    mmcm_reset_sequencer #(
        .RST_CYCLES   (RSTC),
        .LOCK_TIMEOUT (LTO),
        .HOLD_CYCLES  (HOLDC),
        .SYNC_STAGES  (SYNC),
        .RETRY_W      (RW)
    ) dut (
        .clk_i         (clk),
        .rst_ni        (rst_n),
        .soft_rst_i    (soft_rst),
        .mmcm_locked_i (mmcm_locked),
        .mmcm_rst_o    (mmcm_rst),
        .sys_rst_no    (sys_rst_n),
        .lock_lost_o   (lock_lost),
        .timeout_o     (timeout),
        .retry_count_o (retry_count),
        .state_o       (state)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            if (n_fail <= 50) begin
                $display("FAIL %s @%0t: got %0d, expected %0d", name, $time, act, exp);
            end
        end
    endtask

    // Behavioural model: tracks the state and the edge index at which it was entered;
    // LOCKED as seen by the sequencer is the input sampled SYNC edges earlier.
    int m_st, m_entry, m_lost, m_retry, m_to, cyc;
    int h1, h2, ls, nxt, el;
    bit m_valid = 1'b0;
    bit reenter;
    logic s_rst, s_soft, s_lk;

    always begin
        @(posedge clk);
        s_rst  = rst_n;
        s_soft = soft_rst;
        s_lk   = mmcm_locked;
        #1;
        cyc++;
        if (s_rst !== 1'b1) begin
            m_st    = MReset;
            m_entry = cyc;
            m_lost  = 0;
            m_retry = 0;
            m_to    = 0;
            h1      = 0;
            h2      = 0;
            m_valid = 1'b1;
        end else if (m_valid) begin
            ls      = h2;
            h2      = h1;
            h1      = (s_lk === 1'b1) ? 1 : 0;
            el      = cyc - m_entry;
            nxt     = m_st;
            m_to    = 0;
            reenter = 1'b0;
            if (s_soft === 1'b1) begin
                if (m_st == MRun && ls == 0) m_lost = 1;
                nxt     = MReset;
                reenter = 1'b1;
            end else begin
                case (m_st)
                    MReset: if (el >= RSTC) nxt = MWait;
                    MWait: begin
                        if (ls == 1) nxt = MHold;
                        else if (el >= LTO) begin
                            nxt  = MReset;
                            m_to = 1;
                            if (m_retry < RetryMax) m_retry++;
                        end
                    end
                    MHold: begin
                        if (ls == 0) nxt = MWait;
                        else if (el >= HOLDC) nxt = MRun;
                    end
                    default: if (ls == 0) begin
                        nxt    = MReset;
                        m_lost = 1;
                    end
                endcase
            end
            if (reenter || nxt != m_st) m_entry = cyc;
            m_st = nxt;
        end
        if (m_valid) begin
            chk("model_state", state, m_st);
            chk("model_mmcm_rst", mmcm_rst, (m_st == MReset) ? 1 : 0);
            chk("model_sys_rst_n", sys_rst_n, (m_st == MRun) ? 1 : 0);
            chk("model_lock_lost", lock_lost, m_lost);
            chk("model_timeout", timeout, m_to);
            chk("model_retry", retry_count, m_retry);
        end
    end

    task automatic step(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic wait_run(input string name);
        int g = 0;
        while (sys_rst_n !== 1'b1 && g < 200) begin
            step(1);
            g++;
        end
        chk(name, sys_rst_n, 1);
    endtask

    task automatic wait_state(input string name, input logic [1:0] st);
        int g = 0;
        while (state !== st && g < 200) begin
            step(1);
            g++;
        end
        chk(name, state, st);
    endtask

    int cnt, wcnt, rcnt, guard;
    int exp_retry [4] = '{1, 2, 3, 3};

    initial begin
        rst_n       = 1'b0;
        soft_rst    = 1'b0;
        mmcm_locked = 1'b0;

        // 1: reset values, then RST held exactly RSTC cycles
        step(3);
        chk("rst_state", state, MReset);
        chk("rst_mmcm_rst", mmcm_rst, 1);
        chk("rst_sys_rst_n", sys_rst_n, 0);
        chk("rst_lock_lost", lock_lost, 0);
        chk("rst_retry", retry_count, 0);
        chk("rst_timeout", timeout, 0);
        rst_n = 1'b1;
        cnt = 0;
        while (mmcm_rst === 1'b1 && cnt < 20) begin
            cnt++;
            step(1);
        end
        chk("rst_len", cnt, 4);
        chk("wait_after_rst", state, MWait);

        // 2: lock rises -> HOLD 3 edges later, RUN 8 edges after that
        mmcm_locked = 1'b1;
        step(2);
        chk("t2_still_wait", state, MWait);
        step(1);
        chk("t2_hold", state, MHold);
        step(7);
        chk("t2_hold_sys", sys_rst_n, 0);
        step(1);
        chk("t2_run_sys", sys_rst_n, 1);
        chk("t2_run_state", state, MRun);

        // 6a: soft reset in RUN
        soft_rst = 1'b1;
        step(1);
        soft_rst = 1'b0;
        chk("t6_soft_state", state, MReset);
        chk("t6_soft_mmcm_rst", mmcm_rst, 1);
        chk("t6_soft_sys", sys_rst_n, 0);
        chk("t6_soft_lost", lock_lost, 0);
        wait_run("t6_relock");

        // 5: lock loss in RUN
        mmcm_locked = 1'b0;
        step(2);
        chk("t5_sys_before", sys_rst_n, 1);
        step(1);
        chk("t5_sys_fall", sys_rst_n, 0);
        chk("t5_mmcm_rst", mmcm_rst, 1);
        chk("t5_lost", lock_lost, 1);
        mmcm_locked = 1'b1;
        wait_run("t5_relock");
        chk("t5_lost_sticky", lock_lost, 1);

        // 6b: soft reset and block reset together -> block reset wins
        soft_rst    = 1'b1;
        rst_n       = 1'b0;
        mmcm_locked = 1'b0;
        step(1);
        chk("t6b_state", state, MReset);
        chk("t6b_mmcm_rst", mmcm_rst, 1);
        chk("t6b_sys", sys_rst_n, 0);
        chk("t6b_lost", lock_lost, 0);
        soft_rst = 1'b0;
        rst_n    = 1'b1;

        // 3: four timeouts, retry counter saturates
        for (int k = 0; k < 4; k++) begin
            wcnt  = 0;
            guard = 0;
            while (timeout !== 1'b1 && guard < 200) begin
                if (state === 2'(MWait)) wcnt++;
                step(1);
                guard++;
            end
            chk("t3_timeout_seen", timeout, 1);
            chk("t3_wait_len", wcnt, LTO);
            chk("t3_retry", retry_count, exp_retry[k]);
            rcnt = 1;
            step(1);
            chk("t3_pulse_width", timeout, 0);
            while (mmcm_rst === 1'b1 && rcnt < 50) begin
                rcnt++;
                step(1);
            end
            chk("t3_rst_len", rcnt, RSTC);
        end

        // 4: one-cycle lock glitch in HOLD
        rst_n = 1'b0;
        step(1);
        rst_n = 1'b1;
        wait_state("t4_wait", 2'(MWait));
        mmcm_locked = 1'b1;
        step(3);
        chk("t4_hold", state, MHold);
        mmcm_locked = 1'b0;
        step(1);
        mmcm_locked = 1'b1;
        step(2);
        chk("t4_back_wait", state, MWait);
        chk("t4_sys", sys_rst_n, 0);
        chk("t4_retry", retry_count, 0);
        step(1);
        chk("t4_rehold", state, MHold);
        step(7);
        chk("t4_not_yet_run", state, MHold);
        step(1);
        chk("t4_run", state, MRun);
        chk("t4_run_sys", sys_rst_n, 1);

        step(2);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
